// File: rtl/multi_ball_engine_if.sv
// Bus bundle between vga_controller/keyboard side and multi_ball_engine:
// sync/raster/key inputs plus RGB, selected-ball index and busy flag.
interface multi_ball_engine_if #(
  parameter int COORD_W = 10,
  parameter int SEL_W   = 2
);
  logic               vs;
  logic               blank;
  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic [7:0]         keycode;
  logic [7:0]         Red;
  logic [7:0]         Green;
  logic [7:0]         Blue;
  logic [SEL_W-1:0]   sel;
  logic               busy;

  modport master (
    output vs, blank, DrawX, DrawY, keycode,
    input  Red, Green, Blue, sel, busy
  );

  modport slave (
    input  vs, blank, DrawX, DrawY, keycode,
    output Red, Green, Blue, sel, busy
  );
endinterface

// File: rtl/multi_ball_engine.sv
// N_BALLS bouncing balls updated once per frame, with a registered RGB pixel path.
// Define SEL_HIGHLIGHT_EN to draw the selected ball white when it wins the pixel.
module multi_ball_engine #(
  parameter int N_BALLS   = 4,
  parameter int COORD_W   = 10,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int BALL_SIZE = 4,
  parameter int STEP      = 1
) (
  input logic                  Clk,
  input logic                  Reset,
  multi_ball_engine_if.slave   bus
);

  localparam int SEL_W = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
  localparam int DW    = 2 * COORD_W + 1;
  localparam int PW    = 2 * DW;

  localparam logic [COORD_W-1:0] P_STEP   = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] N_STEP   = COORD_W'(-STEP);
  localparam logic [SEL_W-1:0]   LAST_IDX = SEL_W'(N_BALLS - 1);

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEY,
    S_UPDATE
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [COORD_W-1:0]        r_x  [N_BALLS];
  logic [COORD_W-1:0]        r_y  [N_BALLS];
  logic signed [COORD_W-1:0] r_vx [N_BALLS];
  logic signed [COORD_W-1:0] r_vy [N_BALLS];

  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_idx;
  logic             r_prevSpace;
  logic             r_vs;
  logic             r_vsPrev;
  logic [23:0]      r_rgb;

  logic             w_tick;
  logic             w_busy;
  logic             w_doKey;
  logic             w_doUpdate;
  logic [SEL_W-1:0] w_selNext;

  logic [COORD_W-1:0]        w_curX;
  logic [COORD_W-1:0]        w_curY;
  logic signed [COORD_W-1:0] w_curVx;
  logic signed [COORD_W-1:0] w_curVy;
  logic signed [COORD_W-1:0] w_nvx;
  logic signed [COORD_W-1:0] w_nvy;
  logic [COORD_W-1:0]        w_nx;
  logic [COORD_W-1:0]        w_ny;

  logic [N_BALLS-1:0] w_hitVec;
  logic [23:0]        w_rgb;
  logic               w_found;

  function automatic logic [COORD_W-1:0] initX(input int i);
    return COORD_W'((X_MAX * (i + 1)) / (N_BALLS + 1));
  endfunction

  function automatic logic [23:0] palette(input int i);
    logic [23:0] c;
    case (i % 4)
      0:       c = 24'hFF5500;
      1:       c = 24'h00FF00;
      2:       c = 24'h00FFFF;
      default: c = 24'hFF00FF;
    endcase
    return c;
  endfunction

  // Frame tick is the falling edge of the registered vs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_vs     <= 1'b0;
      r_vsPrev <= 1'b0;
    end else begin
      r_vs     <= bus.vs;
      r_vsPrev <= r_vs;
    end
  end

  assign w_tick = r_vsPrev & ~r_vs;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_busy      = 1'b0;
    w_doKey     = 1'b0;
    w_doUpdate  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_stateNext = S_KEY;
        end
      end
      S_KEY: begin
        w_busy      = 1'b1;
        w_doKey     = 1'b1;
        w_stateNext = S_UPDATE;
      end
      S_UPDATE: begin
        w_busy     = 1'b1;
        w_doUpdate = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_stateNext = S_IDLE;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  assign w_selNext = (r_sel == LAST_IDX) ? '0 : r_sel + 1'b1;

  // Bounce checks run in order (y then x) and the move uses the post-bounce velocity.
  always_comb begin
    w_curX  = r_x[r_idx];
    w_curY  = r_y[r_idx];
    w_curVx = r_vx[r_idx];
    w_curVy = r_vy[r_idx];

    w_nvy = w_curVy;
    if ((({1'b0, w_curY} + (COORD_W+1)'(BALL_SIZE)) >= (COORD_W+1)'(Y_MAX)) &&
        !w_nvy[COORD_W-1] && (w_nvy != '0)) begin
      w_nvy = N_STEP;
    end
    if ((w_curY <= COORD_W'(BALL_SIZE)) && w_nvy[COORD_W-1]) begin
      w_nvy = P_STEP;
    end

    w_nvx = w_curVx;
    if ((({1'b0, w_curX} + (COORD_W+1)'(BALL_SIZE)) >= (COORD_W+1)'(X_MAX)) &&
        !w_nvx[COORD_W-1] && (w_nvx != '0)) begin
      w_nvx = N_STEP;
    end
    if ((w_curX <= COORD_W'(BALL_SIZE)) && w_nvx[COORD_W-1]) begin
      w_nvx = P_STEP;
    end

    w_nx = w_curX + $unsigned(w_nvx);
    w_ny = w_curY + $unsigned(w_nvy);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < N_BALLS; i++) begin
        r_x[i]  <= initX(i);
        r_y[i]  <= COORD_W'(Y_MAX / 2);
        r_vx[i] <= P_STEP;
        r_vy[i] <= ((i % 2) == 0) ? P_STEP : N_STEP;
      end
      r_sel       <= '0;
      r_idx       <= '0;
      r_prevSpace <= 1'b0;
    end else begin
      if (w_doKey) begin
        case (bus.keycode)
          KEY_W: begin
            r_vx[r_sel] <= '0;
            r_vy[r_sel] <= N_STEP;
          end
          KEY_S: begin
            r_vx[r_sel] <= '0;
            r_vy[r_sel] <= P_STEP;
          end
          KEY_A: begin
            r_vx[r_sel] <= N_STEP;
            r_vy[r_sel] <= '0;
          end
          KEY_D: begin
            r_vx[r_sel] <= P_STEP;
            r_vy[r_sel] <= '0;
          end
          KEY_SPACE: begin
            if (!r_prevSpace) begin
              r_sel <= w_selNext;
            end
          end
          default: begin
          end
        endcase
        r_prevSpace <= (bus.keycode == KEY_SPACE);
        r_idx       <= '0;
      end
      if (w_doUpdate) begin
        r_x[r_idx]  <= w_nx;
        r_y[r_idx]  <= w_ny;
        r_vx[r_idx] <= w_nvx;
        r_vy[r_idx] <= w_nvy;
        r_idx       <= r_idx + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_BALLS; g++) begin : g_hit
    logic signed [DW-1:0] w_dx;
    logic signed [DW-1:0] w_dy;
    logic signed [PW-1:0] w_d2;

    assign w_dx = $signed({{(DW-COORD_W){1'b0}}, bus.DrawX}) -
                  $signed({{(DW-COORD_W){1'b0}}, r_x[g]});
    assign w_dy = $signed({{(DW-COORD_W){1'b0}}, bus.DrawY}) -
                  $signed({{(DW-COORD_W){1'b0}}, r_y[g]});
    assign w_d2 = w_dx * w_dx + w_dy * w_dy;
    assign w_hitVec[g] = (w_d2 <= $signed(PW'(BALL_SIZE * BALL_SIZE)));
  end

  // Lowest-index hitting ball wins; blanking forces black.
  always_comb begin
    w_rgb   = 24'h000040;
    w_found = 1'b0;
    for (int i = 0; i < N_BALLS; i++) begin
      if (!w_found && w_hitVec[i]) begin
        w_found = 1'b1;
        w_rgb   = palette(i);
`ifdef SEL_HIGHLIGHT_EN
        if (SEL_W'(i) == r_sel) begin
          w_rgb = 24'hFFFFFF;
        end
`endif
      end
    end
    if (!bus.blank) begin
      w_rgb = 24'h000000;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rgb <= 24'h000000;
    end else begin
      r_rgb <= w_rgb;
    end
  end

  assign bus.Red   = r_rgb[23:16];
  assign bus.Green = r_rgb[15:8];
  assign bus.Blue  = r_rgb[7:0];
  assign bus.sel   = r_sel;
  assign bus.busy  = w_busy;

endmodule

// File: tb/tb_multi_ball_engine.sv
// Scoreboard bench for multi_ball_engine: frame ticks with random keys, pixel probes
// around model ball centres checked one cycle later by an independent monitor.
module tb_multi_ball_engine;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int XM = 639;
  localparam int YM = 479;
  localparam int BS = 4;
  localparam int ST = 1;
  localparam int SW = 2;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  multi_ball_engine_if #(.COORD_W(CW), .SEL_W(SW)) busIf ();

  multi_ball_engine #(
    .N_BALLS(N), .COORD_W(CW), .X_MAX(XM), .Y_MAX(YM), .BALL_SIZE(BS), .STEP(ST)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (busIf.slave)
  );

  int vectorCount = 0;
  int miscompareCount = 0;

  int mx [N];
  int my [N];
  int mvx[N];
  int mvy[N];
  int msel;
  bit mprevSpace;

  typedef struct {
    logic [23:0] rgb;
    int          px;
    int          py;
    bit          bl;
  } expT;

  expT expQ[$];
  expT monE;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectorCount++;
    if (actual != expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = XM * (i + 1) / (N + 1);
      my[i]  = YM / 2;
      mvx[i] = ST;
      mvy[i] = (i % 2 == 0) ? ST : -ST;
    end
    msel = 0;
    mprevSpace = 1'b0;
  endtask

  task automatic modelFrame(input int key);
    case (key)
      'h1A: begin mvx[msel] = 0;   mvy[msel] = -ST; end
      'h16: begin mvx[msel] = 0;   mvy[msel] = ST;  end
      'h04: begin mvx[msel] = -ST; mvy[msel] = 0;   end
      'h07: begin mvx[msel] = ST;  mvy[msel] = 0;   end
      'h2C: if (!mprevSpace) msel = (msel + 1) % N;
      default: ;
    endcase
    mprevSpace = (key == 'h2C);
    for (int i = 0; i < N; i++) begin
      if (my[i] + BS >= YM && mvy[i] > 0) mvy[i] = -ST;
      if (my[i] <= BS && mvy[i] < 0) mvy[i] = ST;
      if (mx[i] + BS >= XM && mvx[i] > 0) mvx[i] = -ST;
      if (mx[i] <= BS && mvx[i] < 0) mvx[i] = ST;
      mx[i] += mvx[i];
      my[i] += mvy[i];
    end
  endtask

  function automatic logic [23:0] expectedRgb(input int px, input int py, input bit bl);
    logic [23:0] pal [4];
    pal[0] = 24'hFF5500;
    pal[1] = 24'h00FF00;
    pal[2] = 24'h00FFFF;
    pal[3] = 24'hFF00FF;
    if (!bl) return 24'h000000;
    for (int i = 0; i < N; i++) begin
      int dx = px - mx[i];
      int dy = py - my[i];
      if (dx * dx + dy * dy <= BS * BS) begin
`ifdef SEL_HIGHLIGHT_EN
        if (i == msel) return 24'hFFFFFF;
`endif
        return pal[i % 4];
      end
    end
    return 24'h000040;
  endfunction

  // Monitor: the registered pixel for the probe driven on the previous negedge.
  always @(posedge Clk) begin
    #1;
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput($sformatf("pixel(%0d,%0d,blank=%0d)", monE.px, monE.py, monE.bl),
                  int'({busIf.Red, busIf.Green, busIf.Blue}), int'(monE.rgb));
    end
  end

  task automatic applyStimulus(input int px, input int py, input bit bl);
    @(negedge Clk);
    busIf.DrawX = CW'(px);
    busIf.DrawY = CW'(py);
    busIf.blank = bl;
    expQ.push_back('{expectedRgb(px, py, bl), px, py, bl});
  endtask

  task automatic pixelBurst(input int n);
    for (int k = 0; k < n; k++) begin
      int b  = int'($urandom_range(0, N - 1));
      int px = mx[b] + int'($urandom_range(0, 12)) - 6;
      int py = my[b] + int'($urandom_range(0, 12)) - 6;
      bit bl = ($urandom_range(0, 7) != 0);
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      if (px > 1023) px = 1023;
      if (py > 1023) py = 1023;
      applyStimulus(px, py, bl);
    end
    @(negedge Clk);
  endtask

  task automatic frameTick(input int key, input bit doubleEdge);
    int busyCycles = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge Clk);
      if (busIf.busy) busyCycles++;
      busIf.keycode = 8'(key);
      if (doubleEdge) busIf.vs = (j == 0 || j == 2) ? 1'b0 : 1'b1;
      else            busIf.vs = (j < 2) ? 1'b0 : 1'b1;
    end
    modelFrame(key);
    checkOutput("busyCycles", busyCycles, N + 1);
    checkOutput("sel", int'(busIf.sel), msel);
  endtask

  task automatic resetMidUpdate();
    bit found = 1'b0;
    @(negedge Clk);
    busIf.keycode = 8'h07;
    busIf.vs = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge Clk);
      busIf.vs = 1'b1;
      if (busIf.busy) found = 1'b1;
    end
    if (!found) checkOutput("busyStart", 0, 1);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    modelReset();
    checkOutput("busyAfterReset", int'(busIf.busy), 0);
    checkOutput("selAfterReset", int'(busIf.sel), 0);
    checkOutput("rgbAfterReset", int'({busIf.Red, busIf.Green, busIf.Blue}), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    busIf.keycode = 8'h00;
  endtask

  initial begin
    int keys[7];
    keys = '{'h00, 'h1A, 'h16, 'h04, 'h07, 'h2C, 'h55};

    Reset = 1'b0;
    busIf.vs = 1'b1;
    busIf.blank = 1'b1;
    busIf.DrawX = '0;
    busIf.DrawY = '0;
    busIf.keycode = 8'h00;
    modelReset();
    repeat (3) @(negedge Clk);
    checkOutput("resetBusy", int'(busIf.busy), 0);
    checkOutput("resetSel", int'(busIf.sel), 0);
    checkOutput("resetRgb", int'({busIf.Red, busIf.Green, busIf.Blue}), 0);
    Reset = 1'b1;

    $display("[TB] reset-state pixels");
    applyStimulus(127, 239, 1'b1);
    applyStimulus(0, 0, 1'b1);
    applyStimulus(127, 239, 1'b0);
    pixelBurst(20);

    $display("[TB] three idle frames");
    repeat (3) frameTick('h00, 1'b0);
    applyStimulus(130, 242, 1'b1);
    applyStimulus(258, 236, 1'b1);
    applyStimulus(386, 242, 1'b1);
    applyStimulus(514, 236, 1'b1);
    pixelBurst(30);

    $display("[TB] ball 0 driven down into the bottom edge");
    for (int t = 0; t < 240; t++) begin
      frameTick('h16, 1'b0);
      if (t % 40 == 0 || (t >= 233 && t <= 239)) pixelBurst(6);
    end

    $display("[TB] space edge detection and wrap");
    repeat (3) frameTick('h2C, 1'b0);
    for (int r = 0; r < 3; r++) begin
      frameTick('h00, 1'b0);
      frameTick('h2C, 1'b0);
    end
    pixelBurst(10);

    $display("[TB] second vs edge while busy");
    frameTick('h00, 1'b1);
    pixelBurst(20);

    $display("[TB] random keys");
    for (int t = 0; t < 40; t++) begin
      frameTick(keys[$urandom_range(0, 6)], 1'b0);
      if (t % 4 == 0) pixelBurst(8);
    end

    $display("[TB] reset during update");
    frameTick('h00, 1'b0);
    frameTick('h2C, 1'b0);
    resetMidUpdate();
    pixelBurst(20);
    frameTick('h00, 1'b0);
    pixelBurst(20);

    repeat (3) @(negedge Clk);
    if (expQ.size() != 0) begin
      miscompareCount++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending, expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule

// File: doc/multi_ball_engine.md
Name: multi_ball_engine

Overview:
- Parametrised successor to the single-ball sprite path: maintains N_BALLS independently bouncing balls, updates all of them once per frame, and produces registered per-pixel RGB for the VGA DAC.
- Sits between vga_controller (supplies vs, blank, DrawX, DrawY) and the VGA output pins.
- Keyboard steers one selected ball; Space cycles which ball is selected.

Parameters:
- N_BALLS, 4: number of balls, 1..8.
- COORD_W, 10: coordinate and velocity width.
- X_MAX, 639: rightmost visible column.
- Y_MAX, 479: bottom visible row.
- BALL_SIZE, 4: ball radius in pixels.
- STEP, 1: speed per frame in pixels. Must satisfy 1 ≤ STEP < BALL_SIZE.

Ports:
- Clk  in  1  pixel/system clock.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- vs  in  1  vertical sync from vga_controller, active-low.
- blank  in  1  0 = blanking interval.
- DrawX  in  COORD_W  current pixel column.
- DrawY  in  COORD_W  current pixel row.
- keycode  in  8  USB HID keycode; 0x00 = no key.
- Red, Green, Blue  out  8 each  pixel colour.
- sel  out  $clog2(N_BALLS) (min 1)  index of the selected ball.
- busy  out  1  high while a frame update is in progress.

Behaviour:
- Per-ball state: x, y unsigned COORD_W; vx, vy signed COORD_W.
- Reset values:
  - x[i] = X_MAX*(i+1)/(N_BALLS+1), integer division at elaboration.
  - y[i] = Y_MAX/2.
  - vx[i] = +STEP.
  - vy[i] = +STEP for even i, -STEP for odd i.
  - sel = 0, busy = 0, Red/Green/Blue = 0, FSM in IDLE, prev_space = 0.
- vs is registered once in Clk. Its falling edge (1→0) is the frame tick.
- FSM:
  - IDLE: on tick → KEY; otherwise stay.
  - KEY (1 cycle): apply keycode to ball[sel]:
    - 0x1A (W): vx=0, vy=-STEP.
    - 0x16 (S): vx=0, vy=+STEP.
    - 0x04 (A): vx=-STEP, vy=0.
    - 0x07 (D): vx=+STEP, vy=0.
    - 0x2C (Space) with prev_space=0: sel = (sel+1) mod N_BALLS. Velocities unchanged.
    - Any other code: no change.
    - prev_space <= (keycode==0x2C). Go to UPDATE, idx=0.
  - UPDATE (N_BALLS cycles, one ball per cycle at idx), bounce rules in order:
    1. If y + BALL_SIZE ≥ Y_MAX and vy > 0: vy = -STEP.
    2. If y ≤ BALL_SIZE and vy < 0: vy = +STEP.
    3. The same two rules apply to x against X_MAX.
    4. Then x += vx, y += vy, using the post-bounce velocities.
    - The key velocity from KEY is overridden by a bounce in the same frame.
    - After ball N_BALLS-1 → IDLE.
  - busy = 1 in KEY and UPDATE.
  - A tick arriving while busy is ignored (not queued).
- Position arithmetic is COORD_W-bit modular. No wrap occurs given the STEP < BALL_SIZE constraint.
- Pixel path, 1-cycle latency (outputs reflect DrawX/DrawY/blank sampled on the previous edge):
  - Ball i hits when dx² + dy² ≤ BALL_SIZE², with dx = DrawX - x[i] and dy = DrawY - y[i], computed signed at 2*COORD_W+1 bits.
  - Lowest hitting index wins.
  - Palette by i mod 4: 0 = FF,55,00; 1 = 00,FF,00; 2 = 00,FF,FF; 3 = FF,00,FF.
  - No hit: background 00,00,40.
  - blank = 0: output 00,00,00.
  - The pixel path reads live ball registers. Tearing during UPDATE is acceptable because UPDATE starts inside vertical blanking.
- Reset asserted at any point, including mid-UPDATE, restores all reset values immediately. Partially updated balls are discarded.

Optional Feature:
- Macro: SEL_HIGHLIGHT_EN.
- Defined: the selected ball, when it is the winning hit, is drawn FF,FF,FF.
- Undefined: the selected ball uses its palette colour, and no extra comparator is built.

Test Plan:
1. Reset release, defaults, 3 frame ticks, keycode 0 → x = 130,258,386,514; y = 242,236,242,236. busy high exactly 5 cycles per tick.
2. keycode 0x16 (S) on ball 0, 240 ticks → y[0] reaches 475 after 236 ticks (240→475 needs 235 moves post-frame-1), then vy=-1 and y[0] decreases to 474 on the next tick. No value exceeds 475.
3. keycode 0x2C held for 3 ticks → sel = 1, once only. Release for one tick, press again → sel = 2. Repeat twice → sel = 0 (wrap).
4. After reset, DrawX=127, DrawY=239, blank=1 → next cycle RGB = FF,FF,FF with SEL_HIGHLIGHT_EN, FF,55,00 without. DrawX=0, DrawY=0 → 00,00,40. blank=0 → 00,00,00.
5. Reset pulled low on the 2nd UPDATE cycle → busy=0 and all x/y/vx/vy/sel equal reset values within the same cycle. The next tick proceeds normally.
6. A second vs falling edge injected while busy=1 → ignored. Positions advance by exactly one STEP for that frame.
